// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types and constants for the quadrature step decoder.
//   qdec_state_e : decoder FSM states (QDEC_PRIME after reset, QDEC_TRACK when decoding)
//   G0..G3       : quadrature Gray codes {A,B} in forward order 00 -> 01 -> 11 -> 10
//   next_fwd()   : Gray code one forward quarter-step after g
package qdec_pkg;

  typedef enum logic [0:0] {
    QDEC_PRIME,
    QDEC_TRACK
  } qdec_state_e;

  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;

  function automatic logic [1:0] next_fwd(input logic [1:0] g);
    logic [1:0] n;
    case (g)
      G0:      n = G1;
      G1:      n = G2;
      G2:      n = G3;
      default: n = G0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qdec_sync2.sv
// qdec_sync2: two-flop synchronizer for asynchronous inputs.
//   Width : number of independent bits synchronized
//   clk   : destination clock
//   rst   : asynchronous active-high reset, clears both stages to 0
//   d_i   : raw asynchronous input vector
//   q_o   : synchronized output (second flop stage)
module qdec_sync2 #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns raw rotary-encoder quadrature phases into step pulses.
//   DEB_CYCLES : stable cycles needed by the glitch filter (1..15)
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   A, B       : raw quadrature phases, asynchronous to clk
//   E          : one-cycle step pulse per legal quarter-step
//   F          : step direction, 1 = forward, 0 = reverse; holds between steps
//   err        : one-cycle pulse on an illegal double-bit transition
// Build option: define QDEC_DEBOUNCE_EN to compile in the glitch filter; otherwise the
// synchronized inputs feed the decoder directly and DEB_CYCLES has no effect.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  output logic E,
  output logic F,
  output logic err
);

  if ((DEB_CYCLES < 1) || (DEB_CYCLES > 15)) begin : g_deb_range
    $error("quad_step_decoder: DEB_CYCLES must be in 1..15");
  end

  logic [1:0] sync;
  logic [1:0] filt;

  qdec_sync2 #(
    .Width(2)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i({A, B}),
    .q_o(sync)
  );

`ifdef QDEC_DEBOUNCE_EN
  localparam logic [3:0] DebCnt = 4'(DEB_CYCLES);

  logic [1:0] cand_q;
  logic [1:0] filt_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  // A new value must be seen DEB_CYCLES times in a row before it is accepted; any
  // difference from the candidate restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else if (sync == filt_q) begin
      cnt_q <= '0;
    end else if (sync != cand_q) begin
      cand_q <= sync;
      if (DebCnt == 4'd1) begin
        filt_q <= sync;
        cnt_q  <= '0;
      end else begin
        cnt_q <= 4'd1;
      end
    end else if (cnt_inc == DebCnt) begin
      filt_q <= cand_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync;
`endif

  qdec_state_e state_q;
  logic [1:0]  fill_q;
  logic [1:0]  prev_q;

  // PRIME waits until the synchronizer holds real input before seeding prev, so a
  // non-zero input at reset release is not mistaken for a transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= QDEC_PRIME;
      fill_q  <= '0;
      prev_q  <= G0;
      E       <= 1'b0;
      F       <= 1'b0;
      err     <= 1'b0;
    end else begin
      E   <= 1'b0;
      err <= 1'b0;
      case (state_q)
        QDEC_PRIME: begin
          if (fill_q == 2'd2) begin
            prev_q  <= filt;
            state_q <= QDEC_TRACK;
          end else begin
            fill_q <= fill_q + 2'd1;
          end
        end
        QDEC_TRACK: begin
          // prev always follows filt, so an illegal jump resynchronizes decoding.
          prev_q <= filt;
          if (filt == next_fwd(prev_q)) begin
            E <= 1'b1;
            F <= 1'b1;
          end else if (prev_q == next_fwd(filt)) begin
            E <= 1'b1;
            F <= 1'b0;
          end else if (filt != prev_q) begin
            err <= 1'b1;
          end
        end
        default: state_q <= QDEC_PRIME;
      endcase
    end
  end

endmodule
